// File: rtl/start_ctrl.sv
// Push-button front end for the 4-bit up counter: sync, debounce, rising-edge detect, run/idle toggle.
// Optional feature macro START_AUTOSTOP_EN: ends a run when count reaches STOP_VAL and pulses done.
module start_ctrl #(
    parameter int         DB_CYCLES = 4,
    parameter int         DB_W      = 3,
    parameter logic [3:0] STOP_VAL  = 4'hF
) (
    input  logic       clk,
    input  logic       s_reset,
    input  logic       btn_raw,
    input  logic [3:0] count,
    output logic       start,
    output logic       press,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            r_sync_p0;
    logic            r_sync_p1;
    logic            r_btn_db_p2;
    logic            r_btn_db_p3;
    logic [DB_W-1:0] r_db_cnt;
    state_t          r_state;
    logic            r_start;
    logic            w_press;
    logic            w_autostop;

    // Stage p0/p1: two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= btn_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Stage p2: accept a new level only after DB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_btn_db_p2 <= 1'b0;
            r_db_cnt    <= '0;
        end else if (r_sync_p1 == r_btn_db_p2) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_btn_db_p2 <= r_sync_p1;
            r_db_cnt    <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
        end
    end

    // Stage p3: delayed debounced level for rising-edge detection
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_btn_db_p3 <= 1'b0;
        end else begin
            r_btn_db_p3 <= r_btn_db_p2;
        end
    end

    assign w_press = r_btn_db_p2 & ~r_btn_db_p3;

`ifdef START_AUTOSTOP_EN
    logic r_done;

    assign w_autostop = (r_state == RUN) && (count == STOP_VAL);

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_autostop;
        end
    end

    assign done = r_done;
`else
    logic w_unused_count;

    assign w_unused_count = ^(count ^ STOP_VAL);
    assign w_autostop     = 1'b0;
    assign done           = 1'b0;
`endif

    // Autostop outranks a coincident press, which is then simply consumed
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_state <= IDLE;
            r_start <= 1'b0;
        end else if (w_autostop) begin
            r_state <= IDLE;
            r_start <= 1'b0;
        end else if (w_press) begin
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                    r_start <= 1'b1;
                end
                RUN: begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign start = r_start;
    assign press = w_press;

endmodule
